// File: rtl/riscv_data_memory.sv
// riscv_data_memory: word RAM with RISC-V sized loads/stores, post-reset fill, optional DMEM_MISALIGN_CHECK_EN
module riscv_data_memory #(
  parameter int DEPTH = 32,
  parameter int INIT_MODE = 1,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] position,
  input  logic [31:0] writeData,
  input  logic        memWrite,
  input  logic        memRead,
  input  logic [2:0]  funct3,
  output logic [31:0] readData,
  output logic        readValid,
  output logic        ready,
  output logic        misaligned
);
  typedef enum logic {INIT, IDLE} state_t;
  state_t state, state_next;
  logic [31:0] mem [DEPTH];
  logic [ADDR_W-1:0] count, idx;
  logic [1:0] lane;
  logic [3:0] be;
  logic [31:0] wd, word, sh, load;
  logic idle, bad, we, rd, unused_hi;
  assign unused_hi = ^position[31:ADDR_W+2];
  assign idle = state == IDLE;
  assign lane = funct3[1] ? 2'b00 : funct3[0] ? {position[1], 1'b0} : position[1:0];
`ifdef DMEM_MISALIGN_CHECK_EN
  assign bad = funct3[1] ? position[1:0] != 2'b00 : funct3[0] & position[0];
`else
  assign bad = 1'b0;
`endif
  assign we = idle ? memWrite & ~bad : 1'b1;
  assign rd = idle & memRead & ~memWrite & ~bad;
  assign idx = idle ? position[ADDR_W+1:2] : count;
  assign be = !idle ? 4'hF : funct3[1] ? 4'hF : funct3[0] ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b0001 << lane;
  assign wd = !idle ? (INIT_MODE != 0 ? 32'(count) : 32'h0) : funct3[1] ? writeData : funct3[0] ? {2{writeData[15:0]}} : {4{writeData[7:0]}};
  assign word = mem[idx];
  assign sh = word >> {lane, 3'b000};
  assign load = funct3[1] ? word : funct3[0] ? {{16{~funct3[2] & sh[15]}}, sh[15:0]} : {{24{~funct3[2] & sh[7]}}, sh[7:0]};
  // leave INIT once the last word has been filled
  always_comb state_next = (state == INIT && count == ADDR_W'(DEPTH - 1)) ? IDLE : state;
  // control state, fill counter and registered load result
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= INIT;
      count <= '0;
      readData <= '0;
      readValid <= 1'b0;
      ready <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      state <= state_next;
      count <= idle ? count : count + 1'b1;
      ready <= state_next == IDLE;
      readValid <= rd;
      misaligned <= idle & (memWrite | memRead) & bad;
      if (rd) readData <= load;
    end
  // byte-lane writes: fill words during INIT, stores during IDLE; contents survive reset
  always_ff @(posedge clock)
    if (we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
endmodule

// File: tb/tb_riscv_data_memory.sv
// tb_riscv_data_memory: directed checks of fill, sized loads/stores, collisions and misalignment
module tb_riscv_data_memory;
  logic clock = 1'b0, reset = 1'b0, memWrite = 1'b0, memRead = 1'b0;
  logic [31:0] position = '0, writeData = '0;
  logic [2:0] funct3 = 3'b010;
  logic [31:0] readData;
  logic readValid, ready, misaligned;
  int vectors = 0, errors = 0;
  logic [31:0] held;
  int n;

  riscv_data_memory #(.DEPTH(32), .INIT_MODE(1)) dut (
    .clock(clock), .reset(reset), .position(position), .writeData(writeData),
    .memWrite(memWrite), .memRead(memRead), .funct3(funct3), .readData(readData),
    .readValid(readValid), .ready(ready), .misaligned(misaligned)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic w, input logic r, input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
    memWrite = w;
    memRead = r;
    position = a;
    funct3 = f;
    writeData = d;
    tick();
    memWrite = 1'b0;
    memRead = 1'b0;
  endtask

  task automatic wait_ready(output int edges);
    edges = 0;
    while (!ready && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", ready); end
    vectors++; if (readValid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", readValid); end
    vectors++; if (readData !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", readData); end
    vectors++; if (misaligned !== 1'b0) begin errors++; $display("FAIL rst_mis: got %b want 0", misaligned); end
    reset = 1'b1;
    wait_ready(n);
    vectors++; if (n !== 32) begin errors++; $display("FAIL ready_edges: got %0d want 32", n); end
  endtask

  task automatic test_init_fill();
    issue(1'b0, 1'b1, 32'h1C, 3'b010, 0);
    vectors++; if (readValid !== 1'b1) begin errors++; $display("FAIL lw_1c_valid: got %b want 1", readValid); end
    vectors++; if (readData !== 32'h7) begin errors++; $display("FAIL lw_1c: got %h want 00000007", readData); end
    tick();
    vectors++; if (readValid !== 1'b0) begin errors++; $display("FAIL valid_pulse: got %b want 0", readValid); end
    issue(1'b0, 1'b1, 32'h7C, 3'b010, 0);
    vectors++; if (readData !== 32'd31) begin errors++; $display("FAIL lw_last: got %h want 0000001f", readData); end
    issue(1'b0, 1'b1, 32'h84, 3'b010, 0);
    vectors++; if (readData !== 32'd1) begin errors++; $display("FAIL lw_wrap: got %h want 00000001", readData); end
  endtask

  task automatic test_extension();
    issue(1'b1, 1'b0, 32'h10, 3'b010, 32'h8081F0F1);
    vectors++; if (readValid !== 1'b0) begin errors++; $display("FAIL sw_novalid: got %b want 0", readValid); end
    issue(1'b0, 1'b1, 32'h10, 3'b000, 0);
    vectors++; if (readData !== 32'hFFFFFFF1) begin errors++; $display("FAIL lb_10: got %h want fffffff1", readData); end
    issue(1'b0, 1'b1, 32'h13, 3'b100, 0);
    vectors++; if (readData !== 32'h00000080) begin errors++; $display("FAIL lbu_13: got %h want 00000080", readData); end
    issue(1'b0, 1'b1, 32'h12, 3'b001, 0);
    vectors++; if (readData !== 32'hFFFF8081) begin errors++; $display("FAIL lh_12: got %h want ffff8081", readData); end
    issue(1'b0, 1'b1, 32'h10, 3'b101, 0);
    vectors++; if (readData !== 32'h0000F0F1) begin errors++; $display("FAIL lhu_10: got %h want 0000f0f1", readData); end
    issue(1'b0, 1'b1, 32'h11, 3'b000, 0);
    vectors++; if (readData !== 32'hFFFFFFF0) begin errors++; $display("FAIL lb_11: got %h want fffffff0", readData); end
  endtask

  task automatic test_partial();
    issue(1'b1, 1'b0, 32'h16, 3'b000, 32'h123456AB);
    issue(1'b0, 1'b1, 32'h14, 3'b010, 0);
    vectors++; if (readData !== 32'h00AB0005) begin errors++; $display("FAIL sb_16: got %h want 00ab0005", readData); end
    issue(1'b1, 1'b0, 32'h1A, 3'b001, 32'h7777BEEF);
    issue(1'b0, 1'b1, 32'h18, 3'b010, 0);
    vectors++; if (readData !== 32'hBEEF0006) begin errors++; $display("FAIL sh_1a: got %h want beef0006", readData); end
  endtask

  task automatic test_simultaneous();
    held = readData;
    issue(1'b1, 1'b1, 32'h08, 3'b010, 32'h1234);
    vectors++; if (readValid !== 1'b0) begin errors++; $display("FAIL both_valid: got %b want 0", readValid); end
    vectors++; if (readData !== held) begin errors++; $display("FAIL both_hold: got %h want %h", readData, held); end
    issue(1'b0, 1'b1, 32'h08, 3'b010, 0);
    vectors++; if (readData !== 32'h1234) begin errors++; $display("FAIL both_store: got %h want 00001234", readData); end
  endtask

  task automatic test_back_to_back();
    memRead = 1'b1;
    position = 32'h0C;
    funct3 = 3'b010;
    tick();
    vectors++; if (readValid !== 1'b1 || readData !== 32'd3) begin errors++; $display("FAIL b2b_0: got %b/%h want 1/00000003", readValid, readData); end
    position = 32'h24;
    tick();
    vectors++; if (readValid !== 1'b1 || readData !== 32'd9) begin errors++; $display("FAIL b2b_1: got %b/%h want 1/00000009", readValid, readData); end
    memRead = 1'b0;
    tick();
    vectors++; if (readValid !== 1'b0 || readData !== 32'd9) begin errors++; $display("FAIL idle_hold: got %b/%h want 0/00000009", readValid, readData); end
    issue(1'b1, 1'b0, 32'h28, 3'b010, 32'hCAFE);
    issue(1'b0, 1'b1, 32'h28, 3'b010, 0);
    vectors++; if (readData !== 32'hCAFE) begin errors++; $display("FAIL st_ld: got %h want 0000cafe", readData); end
  endtask

  task automatic test_misalign();
    issue(1'b1, 1'b0, 32'h21, 3'b010, 32'hDEAD);
`ifdef DMEM_MISALIGN_CHECK_EN
    vectors++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_st: got %b want 1", misaligned); end
`else
    vectors++; if (misaligned !== 1'b0) begin errors++; $display("FAIL mis_st: got %b want 0", misaligned); end
`endif
    tick();
    vectors++; if (misaligned !== 1'b0) begin errors++; $display("FAIL mis_pulse: got %b want 0", misaligned); end
    issue(1'b0, 1'b1, 32'h20, 3'b010, 0);
`ifdef DMEM_MISALIGN_CHECK_EN
    vectors++; if (readData !== 32'd8) begin errors++; $display("FAIL mis_word: got %h want 00000008", readData); end
    issue(1'b0, 1'b1, 32'h22, 3'b010, 0);
    vectors++; if (readValid !== 1'b0 || misaligned !== 1'b1 || readData !== 32'd8) begin errors++; $display("FAIL mis_ld: got %b/%b/%h want 0/1/00000008", readValid, misaligned, readData); end
`else
    vectors++; if (readData !== 32'hDEAD) begin errors++; $display("FAIL mis_word: got %h want 0000dead", readData); end
    issue(1'b0, 1'b1, 32'h13, 3'b001, 0);
    vectors++; if (readValid !== 1'b1 || misaligned !== 1'b0 || readData !== 32'hFFFF8081) begin errors++; $display("FAIL mis_ld: got %b/%b/%h want 1/0/ffff8081", readValid, misaligned, readData); end
`endif
  endtask

  task automatic test_reset_mid_init();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (10) tick();
    reset = 1'b0;
    #1;
    vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b want 0", ready); end
    tick();
    reset = 1'b1;
    wait_ready(n);
    vectors++; if (n !== 32) begin errors++; $display("FAIL mid_edges: got %0d want 32", n); end
    for (int i = 0; i < 32; i += 2) begin
      issue(1'b0, 1'b1, 32'(i * 4), 3'b010, 0);
      vectors++; if (readData !== 32'(i)) begin errors++; $display("FAIL refill_%0d: got %h want %h", i, readData, 32'(i)); end
    end
  endtask

  initial begin
    test_reset();
    test_init_fill();
    test_extension();
    test_partial();
    test_simultaneous();
    test_back_to_back();
    test_misalign();
    test_reset_mid_init();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
